// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - mode encoding, BCD digit limits and BCD increment helpers for clock_ctrl
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_ILLEGAL  = 2'd3
  } mode_e;

  localparam logic [3:0] SEC_T_MAX       = 4'd5;
  localparam logic [3:0] MIN_T_MAX       = 4'd5;
  localparam logic [3:0] HOUR_T_MAX      = 4'd2;
  localparam logic [3:0] HOUR_U_MAX_AT_2 = 4'd3;
  localparam logic [3:0] BCD_MAX         = 4'd9;

  // {tens, units} step of a 00..(t_max)9 field, wrapping back to 00
  function automatic logic [7:0] sexa_inc(input logic [7:0] tu, input logic [3:0] t_max);
    logic [7:0] r;
    if (tu[3:0] != BCD_MAX) r = {tu[7:4], tu[3:0] + 4'd1};
    else if (tu[7:4] != t_max) r = {tu[7:4] + 4'd1, 4'd0};
    else r = 8'h00;
    return r;
  endfunction

  function automatic logic [7:0] hour_inc(input logic [7:0] tu);
    logic [7:0] r;
    if (tu[7:4] == HOUR_T_MAX && tu[3:0] == HOUR_U_MAX_AT_2) r = 8'h00;
    else if (tu[3:0] == BCD_MAX) r = {tu[7:4] + 4'd1, 4'd0};
    else r = {tu[7:4], tu[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, debouncer and one-cycle press detector for an active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_n,
  output logic press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d     = key_n;
    sync2_d     = sync1_q;
    level_d     = level_q;
    level_dly_d = level_q;
    cnt_d       = '0;
    // only an unbroken run of differing samples may flip the accepted level
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else cnt_d = cnt_q + CW'(1);
    end
    press_d = level_dly_q & ~level_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - 24-hour HH:MM:SS BCD time-keeper with 1 Hz prescaler and two-key set mode
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  output logic [3:0] hour_t,
  output logic [3:0] hour_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic [1:0] mode,
  output logic       tick_1hz
);

  localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic          mode_press, inc_press, tick;
  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk   (clk),
    .rstn  (rstn),
    .key_n (key_mode_n),
    .press (mode_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .clk   (clk),
    .rstn  (rstn),
    .key_n (key_inc_n),
    .press (inc_press)
  );

  always_comb begin
    mode_d  = mode_q;
    presc_d = presc_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick    = (mode_q == MODE_RUN) && (presc_q == PRESC_LAST);
    case (mode_q)
      MODE_RUN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          sec_d = sexa_inc(sec_q, SEC_T_MAX);
          if (sec_q == {SEC_T_MAX, BCD_MAX}) begin
            min_d = sexa_inc(min_q, MIN_T_MAX);
            if (min_q == {MIN_T_MAX, BCD_MAX}) hour_d = hour_inc(hour_q);
          end
        end
        if (mode_press) mode_d = MODE_SET_HOUR;
      end
      MODE_SET_HOUR: begin
        presc_d = '0;
        if (mode_press) mode_d = MODE_SET_MIN;
        else if (inc_press) hour_d = hour_inc(hour_q);
      end
      MODE_SET_MIN: begin
        presc_d = '0;
        // leaving set mode restarts a full second from :00
        if (mode_press) begin
          mode_d = MODE_RUN;
          sec_d  = 8'h00;
        end else if (inc_press) begin
          min_d = sexa_inc(min_q, MIN_T_MAX);
        end
      end
      default: begin
        mode_d  = MODE_RUN;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q  <= MODE_RUN;
      presc_q <= '0;
      hour_q  <= 8'h00;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end

  assign hour_t   = hour_q[7:4];
  assign hour_u   = hour_q[3:0];
  assign min_t    = min_q[7:4];
  assign min_u    = min_q[3:0];
  assign sec_t    = sec_q[7:4];
  assign sec_u    = sec_q[3:0];
  assign mode     = mode_q;
  assign tick_1hz = tick;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - self-checking bench for clock_ctrl with a seconds-of-day reference model
module tb_clock_ctrl;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam int DAY    = 86400;

  logic       clk        = 1'b0;
  logic       rstn       = 1'b0;
  logic       key_mode_n = 1'b1;
  logic       key_inc_n  = 1'b1;
  logic [3:0] hour_t, hour_u, min_t, min_u, sec_t, sec_u;
  logic [1:0] mode;
  logic       tick_1hz;

  logic [23:0] cur_bcd;
  logic [26:0] dut_vec;

  int n_cmp  = 0;
  int n_fail = 0;

  clock_ctrl #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key_mode_n (key_mode_n),
    .key_inc_n  (key_inc_n),
    .hour_t     (hour_t),
    .hour_u     (hour_u),
    .min_t      (min_t),
    .min_u      (min_u),
    .sec_t      (sec_t),
    .sec_u      (sec_u),
    .mode       (mode),
    .tick_1hz   (tick_1hz)
  );

  always #5 clk = ~clk;

  assign cur_bcd = {hour_t, hour_u, min_t, min_u, sec_t, sec_u};
  assign dut_vec = {cur_bcd, mode, tick_1hz};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: time of day in seconds, cycles since the last second boundary,
  // and key presses scheduled from how long each pin has been held low.
  int m_tod = 0, m_mode = 0, m_phase = 0, m_edge = 0;
  int lo_mode = 0, lo_inc = 0, ev_mode = -1, ev_inc = -1;

  function automatic int adj_hour(int t);
    int h = t / 3600;
    return t + (((h + 1) % 24) - h) * 3600;
  endfunction

  function automatic int adj_min(int t);
    int m = (t / 60) % 60;
    return t + (((m + 1) % 60) - m) * 60;
  endfunction

  function automatic logic [26:0] model_vec(int tod, int md, int ph);
    int h  = tod / 3600;
    int mi = (tod / 60) % 60;
    int s  = tod % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
            2'(md), (md == 0 && ph == CLK_HZ - 1)};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_tod = 0; m_mode = 0; m_phase = 0; m_edge = 0;
      lo_mode = 0; lo_inc = 0; ev_mode = -1; ev_inc = -1;
    end else begin
      bit mev, iev;
      m_edge++;
      mev = (ev_mode == m_edge);
      iev = (ev_inc == m_edge);
      if (m_mode == 0) begin
        m_phase++;
        if (m_phase == CLK_HZ) begin
          m_phase = 0;
          m_tod   = (m_tod + 1) % DAY;
        end
        if (mev) m_mode = 1;
      end else if (m_mode == 1) begin
        if (mev) m_mode = 2;
        else if (iev) m_tod = adj_hour(m_tod);
      end else begin
        if (mev) begin
          m_mode  = 0;
          m_tod   = m_tod - (m_tod % 60);
          m_phase = 0;
        end else if (iev) begin
          m_tod = adj_min(m_tod);
        end
      end
      // a press takes effect 4 edges after the pin's DEB-th consecutive low sample
      if (!key_mode_n) begin
        lo_mode++;
        if (lo_mode == DEB) ev_mode = m_edge + 4;
      end else lo_mode = 0;
      if (!key_inc_n) begin
        lo_inc++;
        if (lo_inc == DEB) ev_inc = m_edge + 4;
      end else lo_inc = 0;
    end
  end

  always @(negedge clk) begin
    if (rstn) chk("model", dut_vec, model_vec(m_tod, m_mode, m_phase));
  end

  task automatic press(input bit do_mode, input bit do_inc, input int low_n);
    key_mode_n = !do_mode;
    key_inc_n  = !do_inc;
    repeat (low_n) @(negedge clk);
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic set_time(input int hp, input int mp);
    press(1, 0, 6);
    repeat (hp) press(0, 1, 6);
    press(1, 0, 6);
    repeat (mp) press(0, 1, 6);
    press(1, 0, 6);
  endtask

  typedef struct {
    int          hp;
    int          mp;
    int          ticks;
    logic [23:0] exp_bcd;
  } vec_t;

  vec_t tbl [7];
  int   ticks_seen;
  int   guard;

  initial begin
    tbl[0] = '{25, 61, 0,   24'h010100};
    tbl[1] = '{23, 59, 59,  24'h235959};
    tbl[2] = '{23, 59, 60,  24'h000000};
    tbl[3] = '{9,  9,  61,  24'h091001};
    tbl[4] = '{19, 59, 60,  24'h200000};
    tbl[5] = '{24, 60, 5,   24'h000005};
    tbl[6] = '{2,  58, 125, 24'h030005};

    #12;
    chk("rst_digits", cur_bcd, 24'h000000);
    chk("rst_mode", mode, 2'd0);
    chk("rst_tick", tick_1hz, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("first_tick_e%0d", i), tick_1hz, i == 9);
    end
    chk("first_sec", cur_bcd, 24'h000001);

    key_mode_n = 1'b0;
    repeat (7) @(negedge clk);
    chk("hold_mode_e7", mode, 2'd0);
    @(negedge clk);
    chk("hold_mode_e8", mode, 2'd1);
    repeat (12) @(negedge clk);
    key_mode_n = 1'b1;
    ticks_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (tick_1hz) ticks_seen++;
    end
    chk("frozen_ticks", ticks_seen, 0);
    chk("frozen_time", cur_bcd, 24'h000001);
    chk("frozen_mode", mode, 2'd1);

    press(1, 0, 3);
    press(0, 1, 3);
    chk("glitch_mode", mode, 2'd1);
    chk("glitch_time", cur_bcd, 24'h000001);
    press(1, 1, 6);
    chk("coinc_mode", mode, 2'd2);
    chk("coinc_time", cur_bcd, 24'h000001);

    key_mode_n = 1'b0;
    repeat (6) @(negedge clk);
    key_mode_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("back_run_mode", mode, 2'd0);
    chk("back_run_time", cur_bcd, 24'h000000);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk($sformatf("resume_tick_e%0d", j), tick_1hz, j == 9);
    end
    chk("resume_sec", cur_bcd, 24'h000001);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      repeat (10) @(negedge clk);
      set_time(tbl[i].hp, tbl[i].mp);
      repeat (10 * tbl[i].ticks + 1) @(negedge clk);
      chk($sformatf("tbl%0d_time", i), cur_bcd, tbl[i].exp_bcd);
      chk($sformatf("tbl%0d_mode", i), mode, 2'd0);
    end

    do_reset();
    repeat (10) @(negedge clk);
    set_time(12, 34);
    guard = 0;
    while (cur_bcd[7:0] != 8'h56 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_56_in_time", guard < 2000, 1'b1);
    press(1, 0, 6);
    press(1, 0, 6);
    chk("pre_rst_time", cur_bcd, 24'h123456);
    chk("pre_rst_mode", mode, 2'd2);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_time", cur_bcd, 24'h000000);
    chk("async_rst_mode", mode, 2'd0);
    chk("async_rst_tick", tick_1hz, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk($sformatf("post_rst_tick_e%0d", j), tick_1hz, j == 9);
    end

    for (int k = 0; k < 250; k++) begin
      int r;
      r = $urandom_range(0, 12);
      if (r <= 1) repeat ($urandom_range(1, 30)) @(negedge clk);
      else if (r <= 4) press(1, 0, $urandom_range(4, 9));
      else if (r <= 8) press(0, 1, $urandom_range(4, 9));
      else if (r == 9) press(1, 1, $urandom_range(4, 9));
      else if (r == 10) press(1, 0, $urandom_range(1, 3));
      else if (r == 11) press(0, 1, $urandom_range(1, 3));
      else if ($urandom_range(0, 3) == 0) begin
        do_reset();
        repeat (10) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: run still active at %0t, required to end earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
